// File: rtl/quad_decoder_pkg.sv
// Shared definitions for the quadrature decoder: control states, Gray phase
// constants and the forward-successor helper.
package quad_decoder_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [1:0] PH0 = 2'b00;
    localparam logic [1:0] PH1 = 2'b01;
    localparam logic [1:0] PH2 = 2'b11;
    localparam logic [1:0] PH3 = 2'b10;

    // Next phase in the forward direction; the reverse neighbour of p is the q with fwd_next(q) == p.
    function automatic logic [1:0] fwd_next(input logic [1:0] ph);
        logic [1:0] nxt;
        case (ph)
            PH0:     nxt = PH1;
            PH1:     nxt = PH2;
            PH2:     nxt = PH3;
            PH3:     nxt = PH0;
            default: nxt = PH0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/quad_decoder_bit_sync.sv
// Multi-flop synchronizer for a bus of independent asynchronous bits.
// The last stage is the synchronized output.
module bit_sync #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_r;

    // Shift the raw input through DEPTH flop stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_r <= {(DEPTH*WIDTH){1'b0}};
        end else begin
            stage_r <= {stage_r[DEPTH-2:0], d};
        end
    end

    assign q = stage_r[DEPTH-1];

endmodule

// File: rtl/quad_decoder.sv
// Quadrature phase decoder: synchronizes a Gray-coded 2-bit phase, tracks a
// signed position and flags illegal two-bit jumps.
module quad_decoder
    import quad_decoder_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       S,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             step,
    output logic             dir,
    output logic             err,
    output logic             fault
);

    localparam logic [1:0]       WAIT_LAST = 2'(SYNC_STAGES);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    logic [1:0]       ph_s;
    state_t           state_r, state_s;
    logic [1:0]       wcnt_r, wcnt_s;
    logic [1:0]       prev_r, prev_s;
    logic [WIDTH-1:0] count_r, count_s, count_fsm_s;
    logic             fault_r, fault_s, fault_fsm_s;
    logic             dir_r, dir_s;
    logic             step_r, step_s;
    logic             err_r, err_s;

    bit_sync #(
        .WIDTH(2),
        .DEPTH(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst_n(reset),
        .d    (S),
        .q    (ph_s)
    );

    // Next-state and next-output decode for the INIT/RUN control FSM.
    always_comb begin
        state_s     = state_r;
        wcnt_s      = wcnt_r;
        prev_s      = prev_r;
        count_fsm_s = count_r;
        fault_fsm_s = fault_r;
        dir_s       = dir_r;
        step_s      = 1'b0;
        err_s       = 1'b0;
        case (state_r)
            INIT: begin
                // Let the synchronizer fill before trusting ph as the reference phase.
                if (wcnt_r == WAIT_LAST) begin
                    prev_s  = ph_s;
                    wcnt_s  = 2'd0;
                    state_s = RUN;
                end else begin
                    wcnt_s = wcnt_r + 2'd1;
                end
            end
            RUN: begin
                if (ph_s == prev_r) begin
                    prev_s = prev_r;
                end else if (ph_s == fwd_next(prev_r)) begin
                    count_fsm_s = count_r + ONE;
                    step_s      = 1'b1;
                    dir_s       = 1'b1;
                    prev_s      = ph_s;
                end else if (prev_r == fwd_next(ph_s)) begin
                    count_fsm_s = count_r - ONE;
                    step_s      = 1'b1;
                    dir_s       = 1'b0;
                    prev_s      = ph_s;
                end else begin
                    // Both bits flipped: direction unknown, so only flag it and resync.
                    err_s       = 1'b1;
                    fault_fsm_s = 1'b1;
                    prev_s      = ph_s;
                end
            end
            default: begin
                state_s = INIT;
                wcnt_s  = 2'd0;
            end
        endcase

        if (clr) begin
            count_s = {WIDTH{1'b0}};
            fault_s = 1'b0;
        end else begin
            count_s = count_fsm_s;
            fault_s = fault_fsm_s;
        end
    end

    // State, reference phase and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= INIT;
            wcnt_r  <= 2'd0;
            prev_r  <= PH0;
            count_r <= {WIDTH{1'b0}};
            fault_r <= 1'b0;
            dir_r   <= 1'b0;
            step_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            wcnt_r  <= wcnt_s;
            prev_r  <= prev_s;
            count_r <= count_s;
            fault_r <= fault_s;
            dir_r   <= dir_s;
            step_r  <= step_s;
            err_r   <= err_s;
        end
    end

    assign count = count_r;
    assign step  = step_r;
    assign dir   = dir_r;
    assign err   = err_r;
    assign fault = fault_r;

endmodule

// File: doc/quad_decoder.md
QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 Parameter WIDTH, default 8, sets the position counter width in bits.
REQ-002 Parameter SYNC_STAGES, default 2, sets the flip-flop depth of the input synchronizer (legal range 2-3).
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 S  input  2  Gray-coded phase input, asynchronous to clk, produced by the 2-bit sequencing FSM.
REQ-006 clr  input  1  synchronous clear of count and fault, active-high.
REQ-007 count  output  WIDTH  signed position, two's complement.
REQ-008 step  output  1  one-cycle pulse on each legal phase advance.
REQ-009 dir  output  1  direction of the last legal step: 1 = forward, 0 = reverse; held between steps.
REQ-010 err  output  1  one-cycle pulse on an illegal two-bit phase jump.
REQ-011 fault  output  1  sticky error flag.

Function
REQ-012 S shall pass through a SYNC_STAGES-deep synchronizer; its last stage is the synchronized phase, ph.
REQ-013 The forward sequence shall be 00->01->11->10->00; the reverse sequence is its exact inverse.
REQ-014 The control FSM shall have two states, INIT and RUN.
REQ-015 INIT after reset: wait SYNC_STAGES cycles, then load prev<=ph with no count change and no pulses, then go to RUN.
REQ-016 RUN, ph==prev: no change, step=0, err=0.
REQ-017 RUN, forward neighbour: count<=count+1, step=1, dir<=1, prev<=ph.
REQ-018 RUN, reverse neighbour: count<=count-1, step=1, dir<=0, prev<=ph.
REQ-019 RUN, both bits differ: count unchanged, err=1, fault<=1, dir unchanged, prev<=ph (resynchronise to the new phase).
REQ-020 count arithmetic shall be modulo 2^WIDTH with no saturation: 0x7F+1=0x80, 0x00-1=0xFF.
REQ-021 Latency: an S change first captured at rising edge k shall update count/step/dir/err at edge k+SYNC_STAGES.
REQ-022 clr shall take priority over a simultaneous step: count<=0, fault<=0, and prev still updates.
REQ-023 When clr coincides with an illegal jump, the err pulse shall still fire and fault shall end at 0 (clr wins).
REQ-024 clr in INIT shall zero count and fault without altering the INIT sequencing.
REQ-025 step and err shall never be 1 in the same cycle.

Reset
REQ-026 reset low shall asynchronously force: count=0, step=0, dir=0, err=0, fault=0, prev=00, synchronizer flops=00, state=INIT.
REQ-027 Reset deassertion mid-motion shall not generate a step or err; the first comparison is made only after the INIT load.

Structure
REQ-028 A shared package shall hold: the FSM state encoding (INIT, RUN); the phase constants PH0=00, PH1=01, PH2=11, PH3=10; and a forward-successor function.
REQ-029 The synchronizer shall be one sub-module, bit_sync, parameterised by width and depth, async active-low reset.
REQ-030 All outputs shall be driven directly from flip-flops.

Verification
REQ-031 Reset with S=11 held, release, wait 4 clks: count=0, no step, no err, state RUN.
REQ-032 From 00, drive forward 4 phases, one every 4 clks: 4 step pulses, dir=1, count=4, each update SYNC_STAGES edges after capture.
REQ-033 count=1, drive reverse 3 phases: count=0xFE, dir=0.
REQ-034 From 00, jump to 11: single err pulse, fault=1, count unchanged; next 11->10 counts +1.
REQ-035 Assert clr on the same edge as a forward step with count=5: count=0 next cycle, fault=0.
REQ-036 Assert reset low mid-sequence for 1 clk between edges: outputs clear immediately (asynchronously); after re-init, no spurious step or err.
